// File: rtl/regfile_arbiter.sv
// Round-robin arbiter in front of the SFR file: NREQ requesters share one write port
// and one combinational read port through an accept -> issue -> response pipeline.
module regfile_arbiter #(
  parameter int         NREQ      = 3,
  parameter logic [7:0] ADDR_LO   = 8'h81,
  parameter logic [7:0] ADDR_HI   = 8'h85,
  parameter logic [7:0] IDLE_ADDR = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [10*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [9:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           int_wr_addr,
  output logic [9:0]           int_wr_data,
  output logic [7:0]           int_rd_addr,
  input  logic [9:0]           int_rd_data,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [IW-1:0]   last_q, last_d;
  logic            iss_vld_q, iss_vld_d;
  logic [IW-1:0]   iss_id_q, iss_id_d;
  logic            iss_rd_q, iss_rd_d;
  logic            iss_err_q, iss_err_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [9:0]      wr_data_q, wr_data_d;
  logic [7:0]      rd_addr_q, rd_addr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [9:0]      rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [IW-1:0]   cand_s;
  logic            hit_s;
  logic            sel_we_s;
  logic [7:0]      sel_addr_s;
  logic [9:0]      sel_wdata_s;
  logic            sel_legal_s;

  // Round-robin search: first valid requester after the last grant wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s      = IW'((int'(last_q) + k) % NREQ);
      hit_s       = req_valid[cand_s] & ~win_found_s;
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Mux the winning requester's fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = IDLE_ADDR;
    sel_wdata_s = 10'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_we_s    = (win_idx_s == IW'(i)) ? req_we[i]              : sel_we_s;
      sel_addr_s  = (win_idx_s == IW'(i)) ? req_addr[8*i +: 8]     : sel_addr_s;
      sel_wdata_s = (win_idx_s == IW'(i)) ? req_wdata[10*i +: 10]  : sel_wdata_s;
    end
    sel_legal_s = (sel_addr_s >= ADDR_LO) && (sel_addr_s <= ADDR_HI);
  end

  // Accept strobe; held low while reset is asserted.
  always_comb begin
    if (rst_n && win_found_s) begin
      req_ready = onehot(win_idx_s);
    end else begin
      req_ready = '0;
    end
  end

  // Next state: bus values are decided at accept time so the issue-stage outputs are registered.
  always_comb begin
    last_d      = win_found_s ? win_idx_s : last_q;
    iss_vld_d   = win_found_s;
    iss_id_d    = win_idx_s;
    iss_rd_d    = win_found_s & ~sel_we_s & sel_legal_s;
    iss_err_d   = win_found_s & ~sel_legal_s;
    wr_addr_d   = (win_found_s && sel_we_s && sel_legal_s) ? sel_addr_s  : IDLE_ADDR;
    wr_data_d   = (win_found_s && sel_we_s && sel_legal_s) ? sel_wdata_s : 10'd0;
    rd_addr_d   = (win_found_s && !sel_we_s) ? sel_addr_s : IDLE_ADDR;
    rsp_valid_d = iss_vld_q ? onehot(iss_id_q) : '0;
    rsp_rdata_d = iss_rd_q ? int_rd_data : 10'd0;
    rsp_err_d   = iss_vld_q & iss_err_q;
  end

  // Pipeline registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= IW'(NREQ - 1);
      iss_vld_q   <= 1'b0;
      iss_id_q    <= '0;
      iss_rd_q    <= 1'b0;
      iss_err_q   <= 1'b0;
      wr_addr_q   <= IDLE_ADDR;
      wr_data_q   <= 10'd0;
      rd_addr_q   <= IDLE_ADDR;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 10'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      iss_vld_q   <= iss_vld_d;
      iss_id_q    <= iss_id_d;
      iss_rd_q    <= iss_rd_d;
      iss_err_q   <= iss_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign int_wr_addr = wr_addr_q;
  assign int_wr_data = wr_data_q;
  assign int_rd_addr = rd_addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = iss_vld_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a transaction-level model predicts every output each
// cycle; directed scenarios add hand-computed expectations, then random traffic runs.
module tb_regfile_arbiter;

  localparam int NREQ = 3;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [9:0] wd;
  } op_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_we;
  logic [8*NREQ-1:0]   req_addr;
  logic [10*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [9:0]          rsp_rdata;
  logic                rsp_err;
  logic [7:0]          int_wr_addr, int_rd_addr;
  logic [9:0]          int_wr_data, int_rd_data;
  logic                busy;

  logic [9:0]          rf [0:255];
  logic                seed_en;
  int                  n_err, n_chk;

  // model state
  int                  m_last;
  logic                s1_v, s1_we;
  int                  s1_id;
  logic [7:0]          s1_addr;
  logic [9:0]          s1_wd;
  logic                s2_v, s2_err;
  int                  s2_id;
  logic [9:0]          s2_rd;
  logic [9:0]          mregs [0:255];
  logic [NREQ-1:0]     acc_last;
  bit                  rnd_mode;
  logic                rst_cmd;
  op_t                 pend [NREQ][$];

  regfile_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .int_wr_addr(int_wr_addr), .int_wr_data(int_wr_data), .int_rd_addr(int_rd_addr),
    .int_rd_data(int_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [7:0] a);
    return (a >= 8'h81) && (a <= 8'h85);
  endfunction

  function automatic logic [9:0] seed_val(input int a);
    return 10'((a * 97 + 13) % 1024);
  endfunction

  // Register file seen by the arbiter; illegal reads return a poison value.
  always @(posedge clk) begin
    if (seed_en) begin
      for (int a = 0; a < 256; a++) rf[a] <= seed_val(a);
    end else if (legal(int_wr_addr)) begin
      rf[int_wr_addr] <= int_wr_data;
    end
  end

  assign int_rd_data = legal(int_rd_addr) ? rf[int_rd_addr] : 10'h3FF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [7:0] addr, input logic [9:0] wd);
    op_t o;
    o.we = we; o.addr = addr; o.wd = wd;
    return o;
  endfunction

  function automatic int pending_total();
    int t = 0;
    for (int i = 0; i < NREQ; i++) t += pend[i].size();
    return t;
  endfunction

  // Requesters: drop an op once accepted, present the next one (random withdrawals allowed).
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (acc_last[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      if (pend[i].size() > 0 && !(rnd_mode && $urandom_range(0, 7) == 0)) begin
        req_valid[i]          = 1'b1;
        req_we[i]             = pend[i][0].we;
        req_addr[8*i +: 8]    = pend[i][0].addr;
        req_wdata[10*i +: 10] = pend[i][0].wd;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Reference model: predicts all outputs for this cycle, then advances one clock.
  task automatic model_check();
    int win, c;
    logic [NREQ-1:0] e_rdy, e_rv;
    if (!rst_n) begin
      m_last = NREQ - 1;
      s1_v = 1'b0; s1_we = 1'b0; s1_id = 0; s1_addr = 8'h00; s1_wd = 10'h000;
      s2_v = 1'b0; s2_err = 1'b0; s2_id = 0; s2_rd = 10'h000;
      if (seed_en) for (int a = 0; a < 256; a++) mregs[a] = seed_val(a);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_wr_addr", int_wr_addr, 8'h00);
      chk("rst_wr_data", int_wr_data, 0);
      chk("rst_rd_addr", int_rd_addr, 8'h00);
      chk("rst_busy", busy, 0);
      acc_last = '0;
    end else begin
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (win < 0 && req_valid[c]) win = c;
      end
      e_rdy = '0;
      if (win >= 0) e_rdy[win] = 1'b1;
      chk("ready", req_ready, e_rdy);
      chk("wr_addr", int_wr_addr, (s1_v && s1_we && legal(s1_addr)) ? s1_addr : 8'h00);
      chk("wr_data", int_wr_data, (s1_v && s1_we && legal(s1_addr)) ? s1_wd : 10'h000);
      chk("rd_addr", int_rd_addr, (s1_v && !s1_we) ? s1_addr : 8'h00);
      chk("busy", busy, s1_v);
      e_rv = '0;
      if (s2_v) e_rv[s2_id] = 1'b1;
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, s2_v ? s2_rd : 10'h000);
      chk("rsp_err", rsp_err, s2_v & s2_err);
      s2_v   = s1_v;
      s2_id  = s1_id;
      s2_err = !legal(s1_addr);
      s2_rd  = (!s1_we && legal(s1_addr)) ? mregs[s1_addr] : 10'h000;
      if (s1_v && s1_we && legal(s1_addr)) mregs[s1_addr] = s1_wd;
      s1_v = (win >= 0);
      if (win >= 0) begin
        m_last  = win;
        s1_id   = win;
        s1_we   = req_we[win];
        s1_addr = req_addr[8*win +: 8];
        s1_wd   = req_wdata[10*win +: 10];
      end
      acc_last = req_ready;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst_n = rst_cmd;
    drive();
    @(negedge clk);
    model_check();
  endtask

  logic [9:0]      snap [5];
  logic [9:0]      prior;
  logic [NREQ-1:0] exp_g [6];
  int              cnt, bad;

  initial begin
    n_err = 0; n_chk = 0; rnd_mode = 1'b0; acc_last = '0;
    rst_n = 1'b0; rst_cmd = 1'b0; seed_en = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    seed_en = 1'b0;
    rst_cmd = 1'b1;
    repeat (2) tick();

    // single write from requester 1
    pend[1].push_back(mk_op(1'b1, 8'h83, 10'h2AB));
    tick(); chk("sw_ready", req_ready, 3'b010);
    tick(); chk("sw_issue_addr", int_wr_addr, 8'h83); chk("sw_issue_data", int_wr_data, 10'h2AB);
    tick(); chk("sw_rsp_valid", rsp_valid, 3'b010); chk("sw_rsp_err", rsp_err, 0);

    // write then back-to-back read of the same register
    pend[0].push_back(mk_op(1'b1, 8'h85, 10'h155));
    pend[0].push_back(mk_op(1'b0, 8'h85, 10'h000));
    tick(); chk("rb_wr_ready", req_ready, 3'b001);
    tick(); chk("rb_rd_ready", req_ready, 3'b001);
    tick();
    tick(); chk("rb_rsp_valid", rsp_valid, 3'b001); chk("rb_rdata", rsp_rdata, 10'h155);

    // illegal write and illegal read
    for (int a = 0; a < 5; a++) snap[a] = rf[8'h81 + a];
    pend[2].push_back(mk_op(1'b1, 8'h86, 10'h1FF));
    pend[0].push_back(mk_op(1'b0, 8'h80, 10'h000));
    cnt = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid != 3'b000 && rsp_err && rsp_rdata == 10'h000) cnt++;
      if (int_wr_addr != 8'h00) bad++;
    end
    chk("ill_err_responses", cnt, 2);
    chk("ill_wr_bus_idle", bad, 0);

    // idle bus
    repeat (4) tick();
    chk("idle_wr_addr", int_wr_addr, 8'h00);
    chk("idle_rd_addr", int_rd_addr, 8'h00);
    chk("idle_busy", busy, 0);
    for (int a = 0; a < 5; a++) chk("idle_reg_kept", rf[8'h81 + a], snap[a]);

    // reset during the issue cycle of a write
    prior = rf[8'h84];
    pend[2].push_back(mk_op(1'b1, 8'h84, ~prior));
    tick(); chk("rm_ready", req_ready, 3'b100);
    rst_cmd = 1'b0;
    tick(); chk("rm_no_rsp0", rsp_valid, 0);
    tick(); chk("rm_no_rsp1", rsp_valid, 0);
    rst_cmd = 1'b1;
    tick(); chk("rm_no_rsp2", rsp_valid, 0);
    tick(); chk("rm_no_rsp3", rsp_valid, 0);
    chk("rm_reg_kept", rf[8'h84], prior);

    // contention: grants restart at requester 0 and rotate
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 3; j++) pend[i].push_back(mk_op(1'b0, 8'(8'h81 + i), 10'h000));
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6) chk("ct_grant", req_ready, exp_g[k]);
      if (k >= 2) chk("ct_rsp_follow", rsp_valid, exp_g[k-2]);
    end
    repeat (5) tick();

    // random traffic
    rnd_mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() < 3 && $urandom_range(0, 2) != 0) begin
          logic [7:0] ad;
          if ($urandom_range(0, 3) != 0) ad = 8'($urandom_range(8'h81, 8'h85));
          else ad = 8'($urandom_range(8'h7E, 8'h88));
          pend[i].push_back(mk_op(1'($urandom_range(0, 1)), ad, 10'($urandom_range(0, 1023))));
        end
      end
      tick();
    end
    rnd_mode = 1'b0;
    for (int g = 0; g < 200 && pending_total() != 0; g++) tick();
    chk("drain_pending", pending_total(), 0);
    repeat (4) tick();
    for (int a = 8'h81; a <= 8'h85; a++) chk("final_reg", rf[a], mregs[a]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
